// File: rtl/md_pkg.sv
// Shared types for the market-data event path: event record layout, its width,
// side encoding common with cme_md_parser, and the arbiter output-register states.
package md_pkg;

  localparam int MD_EVENT_W = 130;

  localparam logic [1:0] SIDE_NONE = 2'd0;
  localparam logic [1:0] SIDE_BUY  = 2'd1;
  localparam logic [1:0] SIDE_SELL = 2'd2;
  localparam logic [1:0] SIDE_RSVD = 2'd3;

  typedef struct packed {
    logic [31:0] security_id;
    logic [63:0] price;
    logic [31:0] size;
    logic [1:0]  side;
  } md_event_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_e;

endpackage

// File: rtl/md_event_fifo.sv
// Single-clock event FIFO. A push into a full FIFO is accepted only when the
// same cycle also pops; otherwise it is ignored (the caller counts the drop).
module md_event_fifo
  import md_pkg::*;
#(
  parameter int WIDTH = MD_EVENT_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/md_event_arbiter.sv
// Merges N_SRC parser event streams: per-source FIFOs, round-robin grant into a
// registered valid/ready output, and per-source saturating drop counters.
module md_event_arbiter
  import md_pkg::*;
#(
  parameter int N_SRC      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC*32-1:0]        in_security_id,
  input  logic [N_SRC*64-1:0]        in_price,
  input  logic [N_SRC*32-1:0]        in_size,
  input  logic [N_SRC*2-1:0]         in_side,
  input  logic [N_SRC-1:0]           in_valid,
  output logic [31:0]                out_security_id,
  output logic [63:0]                out_price,
  output logic [31:0]                out_size,
  output logic [1:0]                 out_side,
  output logic [$clog2(N_SRC)-1:0]   out_src,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_SRC*CNT_W-1:0]     drop_cnt,
  output logic [N_SRC-1:0]           overflow
);

  localparam int SRC_W = $clog2(N_SRC);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  md_event_t      in_evt    [N_SRC];
  md_event_t      fifo_dout [N_SRC];
  logic [CW-1:0]  fifo_cnt  [N_SRC];
  logic [N_SRC-1:0] fifo_full, fifo_empty, fifo_pop;

  out_state_e       state_q, state_d;
  md_event_t        out_evt_q, out_evt_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_SRC*CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [N_SRC-1:0] overflow_q, overflow_d;

  logic             load;
  logic             gnt_found;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] cand;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign in_evt[i] = '{security_id: in_security_id[i*32 +: 32],
                         price:       in_price[i*64 +: 64],
                         size:        in_size[i*32 +: 32],
                         side:        in_side[i*2 +: 2]};

    md_event_fifo #(
      .WIDTH (MD_EVENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid[i]),
      .pop   (fifo_pop[i]),
      .din   (in_evt[i]),
      .dout  (fifo_dout[i]),
      .count (fifo_cnt[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );

    a_fifo_full_cnt: assert property (@(posedge clk) disable iff (!rst)
      fifo_full[i] == (fifo_cnt[i] == CNT_FULL));
  end

  // Scan offsets from farthest to nearest so the nearest non-empty source after
  // the pointer is the one left in gnt_idx.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = SRC_W'((int'(rr_ptr_q) + k) % N_SRC);
      if (!fifo_empty[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    out_evt_d = out_evt_q;
    out_src_d = out_src_q;
    rr_ptr_d  = rr_ptr_q;
    fifo_pop  = '0;
    load      = (state_q == OUT_EMPTY) || out_ready;
    if (load) begin
      if (gnt_found) begin
        state_d           = OUT_HOLD;
        out_evt_d         = fifo_dout[gnt_idx];
        out_src_d         = gnt_idx;
        rr_ptr_d          = gnt_idx;
        fifo_pop[gnt_idx] = 1'b1;
      end else begin
        state_d = OUT_EMPTY;
      end
    end
  end

  // A strobe into a full FIFO survives only if that FIFO is popped this cycle.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (in_valid[i] && fifo_full[i] && !fifo_pop[i]) begin
        drop_cnt_d[i*CNT_W +: CNT_W] = sat_inc(drop_cnt_q[i*CNT_W +: CNT_W]);
        overflow_d[i]                = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= OUT_EMPTY;
      out_evt_q  <= '0;
      out_src_q  <= '0;
      rr_ptr_q   <= SRC_W'(N_SRC - 1);
      drop_cnt_q <= '0;
      overflow_q <= '0;
    end else begin
      state_q    <= state_d;
      out_evt_q  <= out_evt_d;
      out_src_q  <= out_src_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid       = (state_q == OUT_HOLD);
  assign out_security_id = out_evt_q.security_id;
  assign out_price       = out_evt_q.price;
  assign out_size        = out_evt_q.size;
  assign out_side        = out_evt_q.side;
  assign out_src         = out_src_q;
  assign drop_cnt        = drop_cnt_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_md_event_arbiter.sv
// Randomized and directed bench for md_event_arbiter against a queue-based
// reference model of the merge, grant and drop rules.
module tb_md_event_arbiter;

  localparam int N   = 2;
  localparam int D   = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sec;
    logic [63:0] px;
    logic [31:0] sz;
    logic [1:0]  side;
  } ev_t;

  ev_t          tin [N];
  logic [N-1:0] tvalid = '0;
  logic         out_ready = 1'b0;

  logic [N*32-1:0] in_security_id;
  logic [N*64-1:0] in_price;
  logic [N*32-1:0] in_size;
  logic [N*2-1:0]  in_side;
  logic [31:0]     out_security_id;
  logic [63:0]     out_price;
  logic [31:0]     out_size;
  logic [1:0]      out_side;
  logic [$clog2(N)-1:0] out_src;
  logic            out_valid;
  logic [N*CW-1:0] drop_cnt;
  logic [N-1:0]    overflow;

  always_comb begin
    in_security_id = '0;
    in_price       = '0;
    in_size        = '0;
    in_side        = '0;
    for (int i = 0; i < N; i++) begin
      in_security_id[i*32 +: 32] = tin[i].sec;
      in_price[i*64 +: 64]       = tin[i].px;
      in_size[i*32 +: 32]        = tin[i].sz;
      in_side[i*2 +: 2]          = tin[i].side;
    end
  end

  md_event_arbiter #(
    .N_SRC      (N),
    .FIFO_DEPTH (D),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_security_id  (in_security_id),
    .in_price        (in_price),
    .in_size         (in_size),
    .in_side         (in_side),
    .in_valid        (tvalid),
    .out_security_id (out_security_id),
    .out_price       (out_price),
    .out_size        (out_size),
    .out_side        (out_side),
    .out_src         (out_src),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .drop_cnt        (drop_cnt),
    .overflow        (overflow)
  );

  // Reference model state
  ev_t mq [N][$];
  bit  m_valid;
  ev_t m_out;
  int  m_src;
  int  m_ptr;
  int  m_drop [N];
  bit  m_ovf  [N];

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_drop[i] = 0;
      m_ovf[i]  = 1'b0;
    end
    m_valid = 1'b0;
    m_out   = '{sec: 0, px: 0, sz: 0, side: 0};
    m_src   = 0;
    m_ptr   = N - 1;
  endtask

  // One clock edge: grant decided on pre-edge FIFO contents, then strobes land.
  task automatic model_step();
    int g;
    g = -1;
    if (!m_valid || out_ready) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && mq[j].size() > 0) g = j;
      end
      if (g >= 0) begin
        m_out   = mq[g].pop_front();
        m_src   = g;
        m_ptr   = g;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (tvalid[i]) begin
        if (mq[i].size() < D) begin
          mq[i].push_back(tin[i]);
        end else begin
          if (m_drop[i] < SAT) m_drop[i]++;
          m_ovf[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_sec",  out_security_id, m_out.sec);
      chk("out_px",   out_price,       m_out.px);
      chk("out_size", out_size,        m_out.sz);
      chk("out_side", out_side,        m_out.side);
      chk("out_src",  out_src,         m_src);
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("drop_cnt%0d", i), drop_cnt[i*CW +: CW], m_drop[i]);
      chk($sformatf("overflow%0d", i), overflow[i], m_ovf[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    tvalid = '0;
  endtask

  task automatic set_ev(int i, logic [31:0] sec, logic [63:0] px, logic [31:0] sz, logic [1:0] side);
    tin[i]    = '{sec: sec, px: px, sz: sz, side: side};
    tvalid[i] = 1'b1;
  endtask

  task automatic do_reset();
    tvalid = '0;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_sec",  out_security_id, 0);
    chk("rst_px",   out_price, 0);
    chk("rst_src",  out_src, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) tin[i] = '{sec: 0, px: 0, sz: 0, side: 0};
    model_reset();
    do_reset();

    // Single event, one-cycle latency, then idle
    out_ready = 1'b1;
    set_ev(0, 32'h1234, 64'd100, 32'd5, 2'd1);
    cycle();
    chk("t1_no_bypass", out_valid, 0);
    cycle();
    chk("t1_valid", out_valid, 1);
    chk("t1_sec", out_security_id, 32'h1234);
    chk("t1_src", out_src, 0);
    cycle();
    chk("t1_idle", out_valid, 0);

    // Simultaneous strobes on both sources
    do_reset();
    out_ready = 1'b1;
    set_ev(0, 32'd1, 64'd11, 32'd1, 2'd1);
    set_ev(1, 32'd2, 64'd22, 32'd2, 2'd2);
    cycle();
    cycle();
    chk("t2_sec_a", out_security_id, 1);
    chk("t2_src_a", out_src, 0);
    cycle();
    chk("t2_sec_b", out_security_id, 2);
    chk("t2_src_b", out_src, 1);

    // Backpressure with overflow on source 1
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_ev(1, 32'(10 + k), 64'(1000 + k), 32'(k), 2'd2);
      cycle();
    end
    chk("t3_drop1", drop_cnt[CW +: CW], 1);
    chk("t3_ovf1", overflow[1], 1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_seq", out_security_id, 10 + k);
      cycle();
    end
    chk("t3_drained", out_valid, 0);

    // Fairness with both sources backlogged
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_ev(0, 32'(100 + k), 64'd0, 32'd0, 2'd1);
      set_ev(1, 32'(200 + k), 64'd0, 32'd0, 2'd2);
      cycle();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t4_fair_src", out_src, k % 2);
      cycle();
    end

    // Full FIFO accepts a strobe when popped in the same cycle
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_ev(0, 32'(300 + k), 64'd7, 32'd7, 2'd1);
      cycle();
    end
    out_ready = 1'b1;
    set_ev(0, 32'd399, 64'd9, 32'd9, 2'd2);
    cycle();
    chk("t5_drop0", drop_cnt[0 +: CW], 0);
    chk("t5_ovf0", overflow[0], 0);
    for (int k = 0; k < 6; k++) cycle();

    // Saturating drop counter
    out_ready = 1'b0;
    for (int k = 0; k < 25; k++) begin
      set_ev(0, 32'(500 + k), 64'd1, 32'd1, 2'd0);
      cycle();
    end
    chk("t6_sat", drop_cnt[0 +: CW], SAT);
    chk("t6_ovf", overflow[0], 1);

    // Reset mid-stream, then a fresh event flows normally
    set_ev(1, 32'd600, 64'd6, 32'd6, 2'd1);
    cycle();
    chk("t7_busy", out_valid, 1);
    do_reset();
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_ovf", overflow, 0);
    out_ready = 1'b1;
    set_ev(1, 32'h77, 64'h7777, 32'd7, 2'd3);
    cycle();
    cycle();
    chk("t7_sec", out_security_id, 32'h77);
    chk("t7_src", out_src, 1);

    // Randomized traffic with changing backpressure
    begin
      int ready_pct;
      int valid_pct;
      ready_pct = 70;
      valid_pct = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 200 == 0) begin
          ready_pct = $urandom_range(10, 100);
          valid_pct = $urandom_range(10, 90);
        end
        if (c == 1500) do_reset();
        out_ready = ($urandom_range(1, 100) <= ready_pct);
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(1, 100) <= valid_pct)
            set_ev(i, $urandom, {$urandom, $urandom}, $urandom, 2'($urandom_range(0, 3)));
        end
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_event_arbiter.md
Name: md_event_arbiter

Overview:
Merges trade-event streams from N_SRC cme_md_parser instances into one output stream. Typical use is one parser per channel or per feed line, all feeding a single book/strategy consumer.
Parser outputs have no backpressure, so each source gets a small per-source FIFO. A round-robin scheduler drains the FIFOs into a registered valid/ready output and tags each event with its source index.
Overflows are dropped and counted per source.

Parameters:
N_SRC, 2, number of parser sources (2..8)
FIFO_DEPTH, 4, events buffered per source; power of 2, at least 2
CNT_W, 16, width of each per-source drop counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_security_id  in  N_SRC*32  per-source security_id; source i at [i*32+:32]
in_price  in  N_SRC*64  per-source price; source i at [i*64+:64]
in_size  in  N_SRC*32  per-source size
in_side  in  N_SRC*2  per-source aggressor side
in_valid  in  N_SRC  one-cycle event strobe per source; no backpressure
out_security_id  out  32  granted event field
out_price  out  64  granted event field
out_size  out  32  granted event field
out_side  out  2  granted event field
out_src  out  $clog2(N_SRC)  index of the source that produced the output event
out_valid  out  1  output event valid
out_ready  in  1  consumer accepts the event when out_valid and out_ready are both high
drop_cnt  out  N_SRC*CNT_W  saturating per-source count of dropped events
overflow  out  N_SRC  sticky per-source flag, set on the first drop

Behaviour:
- Reset (rst low, asynchronous): all FIFOs empty, RR pointer=N_SRC-1 (source 0 has first priority), out_valid=0, out_* data=0, out_src=0, drop_cnt=0, overflow=0. Reset mid-operation discards buffered events and any pending output.
- Capture: in_valid[i] high at edge t pushes {security_id, price, size, side} into FIFO i at that edge.
- Full FIFO: a push is accepted when count<FIFO_DEPTH or FIFO i is popped in the same cycle.
  - Otherwise the event is dropped, drop_cnt[i] increments (saturates at all-ones), overflow[i] sets and stays set until reset.
- Output register states:
  - EMPTY: out_valid=0.
  - HOLD: out_valid=1; all out_* stay stable until the handshake completes.
- Load condition: the register loads when EMPTY, or when HOLD with out_ready=1 (back-to-back, one event per cycle sustained).
- Grant: on a load, the first non-empty FIFO strictly after the RR pointer (modulo N_SRC) is popped into the register, and the pointer becomes the granted index.
  - If all FIFOs are empty, the register goes or stays EMPTY.
- Latency: an event pushed at edge t, into an empty FIFO with the output free, appears with out_valid=1 after edge t+1. There is no same-cycle bypass.
- Simultaneous push and pop on one FIFO: both happen and count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- out_ready while out_valid=0 has no effect.
- Ordering: events from one source leave in arrival order. No order is guaranteed across sources.
- Fairness: with all sources continuously backlogged and out_ready=1, grants rotate 0,1,..,N_SRC-1,0,...

Decomposition:
- Package md_pkg:
  - md_event_t packed struct {security_id[31:0], price[63:0], size[31:0], side[1:0]}
  - MD_EVENT_W=130
  - the side encoding constants shared with the parser
- Sub-module md_event_fifo: single-clock, width MD_EVENT_W, depth FIFO_DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Asynchronous active-low reset.
  - Instantiated N_SRC times.
- The top level holds the RR scheduler, output register and drop counters.

Test Plan:
- Single event: src0 strobe with sec=0x1234, px=100, size=5, side=1, out_ready=1 -> one cycle later out_valid=1, out_src=0, fields match; out_valid=0 on the following cycle.
- Simultaneous strobes: src0 (sec=1) and src1 (sec=2) in the same cycle, out_ready=1 -> outputs sec=1/src0 then sec=2/src1 on consecutive cycles.
- Backpressure plus overflow: out_ready=0, src1 strobes 6 events sec=10..15, FIFO_DEPTH=4 -> first event held in the output register, sec=11..14 in the FIFO, sec=15 dropped; drop_cnt[1]=1, overflow[1]=1. Releasing out_ready delivers 10..14 in order.
- Fairness: both FIFOs preloaded with 3 events, out_ready=1 -> out_src sequence 0,1,0,1,0,1.
- Full FIFO with same-cycle pop: src0 FIFO full, output accepting, new strobe -> event accepted, drop_cnt unchanged.
- Reset mid-stream: assert rst with out_valid=1 and FIFOs non-empty -> out_valid=0 and counters 0 immediately (no clock edge needed); after release, the first new event emerges normally.
